mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Iterative 32-bit multiply/divide unit in the execute stage, alongside the ALU. It consumes the same operand1/operand2 buses as the ALU. It holds the HI/LO result pair that feeds the writeback mux. The controller sees start/busy/done and stalls the PC while busy is high.

Parameters:
WIDTH, 32, operand/result width; must be even and >= 8; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled on rising clk edge
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
operand1  input  WIDTH  multiplicand / dividend / MTHI-MTLO source
operand2  input  WIDTH  multiplier / divisor
hi_out  output  WIDTH  HI register (mult upper half / remainder)
lo_out  output  WIDTH  LO register (mult lower half / quotient)
busy  output  1  operation in progress
done  output  1  one-cycle pulse: HI/LO just updated by MULT/DIV
div_by_zero  output  1  last completed DIV/DIVU had operand2 == 0

Behaviour:
- Reset (rst=1 at edge): hi_out=0, lo_out=0, busy=0, done=0, div_by_zero=0, state IDLE, counter 0. Reset mid-operation aborts; no result is written.
- States:
  - IDLE: start=1 with op MULT/MULTU/DIV/DIVU at edge E0 latches operand magnitudes, result signs and op, then goes to RUN with cnt=0; busy=1 from E0.
  - RUN: one iteration per edge, cnt increments; shift-add multiply, restoring divide.
  - Completion: the edge on which cnt reaches WIDTH-1 writes HI/LO, sets busy=0 and done=1 for exactly one cycle, and returns to IDLE. Busy is high for WIDTH cycles (32 by default).
- Back-to-back: start is accepted in the cycle done=1, because state is IDLE.
- start while busy=1 is ignored entirely, including MTHI/MTLO.
- MTHI/MTLO in IDLE: the E0 edge writes hi_out/lo_out = operand1. No busy, no done; div_by_zero is unchanged.
- Undefined op codes (110, 111) in IDLE: no state change.
- Signed ops (MULT/DIV):
  - Operate on two's-complement magnitudes; apply signs at completion.
  - MULT: product sign = sign1 XOR sign2.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign.
  - Overflow case MIN / -1: LO=MIN, HI=0, with no special flag.
- Divide by zero (DIV or DIVU):
  - Still runs the full latency.
  - At completion: LO = all ones, HI = operand1 as latched (signed or not), div_by_zero=1.
  - Any other completed MULT/DIV clears div_by_zero.
- Operands are latched at E0. Input changes during RUN have no effect.
- hi_out/lo_out hold their old values throughout RUN and change only at the completion edge.

Optional Feature:
MDU_EARLY_OUT_EN.
- Defined:
  - Multiply completes on the first RUN edge where the remaining (not yet consumed) multiplier magnitude bits are all zero. Busy cycles = max(1, position of highest set bit of |operand2| + 1).
  - Divide by zero completes after 1 busy cycle.
  - Results and done/div_by_zero semantics are identical to the undefined case.
- Undefined: fixed WIDTH-cycle latency for every MULT/DIV.

Test Plan:
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high exactly 32 cycles, then one done pulse with HI=0xFFFFFFFE, LO=0x00000001; MULT 0xFFFFFFFD x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
2. DIVU 100/7 -> LO=14, HI=2; DIV 0xFFFFFFF9/2 (-7/2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 7/0xFFFFFFFE -> LO=0xFFFFFFFD, HI=1.
3. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, div_by_zero=0; then DIVU 5/0 -> LO=0xFFFFFFFF, HI=5, div_by_zero=1; then MULTU 2x3 -> div_by_zero=0.
4. Start MULTU 3x4; pulse start DIVU 9/3 at busy cycle 5 -> ignored, result HI=0, LO=12. Start DIVU 9/3 in the done cycle -> accepted, LO=3, HI=0 after 32 more cycles.
5. Start MULT, assert rst at busy cycle 10 -> next cycle all outputs 0, busy=0, no done. Then MTHI 0x1234 -> hi_out=0x1234 next cycle, busy stays 0; MTLO 0xABCD -> lo_out=0xABCD.
6. With MDU_EARLY_OUT_EN: MULTU 5x3 -> busy 2 cycles, LO=15, HI=0; MULTU 1x0 -> busy 1 cycle, LO=0; DIVU 8/0 -> busy 1 cycle, LO=0xFFFFFFFF, HI=8, div_by_zero=1.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add MULT/MULTU, restoring DIV/DIVU, MTHI/MTLO moves.
// Latency: WIDTH busy cycles per MULT/DIV; MTHI/MTLO update HI/LO on the accepting edge.
// Backpressure: none; start is only honoured in IDLE, and while busy is high it is dropped.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   start, op                request and opcode (000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                            100 MTHI, 101 MTLO, 110/111 no-op)
//   operand1, operand2       multiplicand/dividend/move source, multiplier/divisor
//   hi_out, lo_out           HI/LO result registers
//   busy, done, div_by_zero  operation in progress, one-cycle completion pulse, last divide had /0
//
// Optional build macro MDU_EARLY_OUT_EN: a multiply finishes as soon as the unconsumed
// multiplier bits are zero, and a divide by zero finishes after a single busy cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    // Multiply: running product. Divide: {remainder, dividend/quotient} shift pair.
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    // Multiply only: multiplicand shifted left one place per iteration.
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    // Multiply: unconsumed multiplier bits (shifted right). Divide: divisor magnitude.
    logic [WIDTH-1:0]       opb_q, opb_d;
    logic [WIDTH-1:0]       a_raw_q, a_raw_d;
    logic                   is_div_q, is_div_d;
    logic                   neg_lo_q, neg_lo_d;   // product sign / quotient sign
    logic                   neg_hi_q, neg_hi_d;   // remainder sign (dividend sign)
    logic                   b_zero_q, b_zero_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   done_q, done_d;
    logic                   dbz_q, dbz_d;

    logic                   signed_op;
    logic [WIDTH-1:0]       mag1, mag2;
    logic [2*WIDTH-1:0]     mul_sum;
    logic [WIDTH:0]         rem_shift, rem_diff;
    logic [2*WIDTH-1:0]     div_step;
    logic [2*WIDTH-1:0]     step;
    logic [WIDTH-1:0]       opb_shift;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quo_fix, rem_fix;
    logic                   last;

    // Operand magnitudes; |MIN| still fits as an unsigned WIDTH-bit value.
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign mag1      = (signed_op && operand1[WIDTH-1]) ? -operand1 : operand1;
    assign mag2      = (signed_op && operand2[WIDTH-1]) ? -operand2 : operand2;

    assign mul_sum   = acc_q + (opb_q[0] ? mcand_q : '0);

    // Restoring divide: shift the next dividend bit into the remainder and try a subtract.
    // The remainder stays below the divisor, so WIDTH+1 bits hold the trial difference and
    // its top bit is the borrow.
    assign rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, opb_q};
    assign div_step  = rem_diff[WIDTH]
                     ? {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                     : {rem_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    assign step      = is_div_q ? div_step : mul_sum;
    assign opb_shift = opb_q >> 1;

    // Sign fix-up applied to this iteration's result when it is the final one.
    assign prod_fix  = neg_lo_q ? -step : step;
    assign quo_fix   = neg_lo_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    assign rem_fix   = neg_hi_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        opb_d    = opb_q;
        a_raw_d  = a_raw_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        b_zero_d = b_zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        last     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d  = S_RUN;
                            cnt_d    = '0;
                            is_div_d = op[1];
                            neg_lo_d = signed_op && (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
                            neg_hi_d = signed_op && operand1[WIDTH-1];
                            b_zero_d = (operand2 == '0);
                            a_raw_d  = operand1;
                            opb_d    = mag2;
                            if (op[1]) begin
                                acc_d   = {{WIDTH{1'b0}}, mag1};
                                mcand_d = '0;
                            end else begin
                                acc_d   = '0;
                                mcand_d = {{WIDTH{1'b0}}, mag1};
                            end
                        end
                        OP_MTHI: hi_d = operand1;
                        OP_MTLO: lo_d = operand1;
                        default: ;
                    endcase
                end
            end

            S_RUN: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (!is_div_q) begin
                    mcand_d = mcand_q << 1;
                    opb_d   = opb_shift;
                end

                last = (cnt_q == LAST);
`ifdef MDU_EARLY_OUT_EN
                if (is_div_q ? b_zero_q : (opb_shift == '0)) begin
                    last = 1'b1;
                end
`endif

                if (last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (!is_div_q) begin
                        hi_d  = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d  = prod_fix[WIDTH-1:0];
                        dbz_d = 1'b0;
                    end else if (b_zero_q) begin
                        hi_d  = a_raw_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        hi_d  = rem_fix;
                        lo_d  = quo_fix;
                        dbz_d = 1'b0;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            opb_q    <= '0;
            a_raw_q  <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            b_zero_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            opb_q    <= opb_d;
            a_raw_q  <= a_raw_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            b_zero_q <= b_zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign hi_out      = hi_q;
    assign lo_out      = lo_q;
    assign busy        = (state_q == S_RUN);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed corner cases plus randomized ops against an arithmetic model.
// Expected results are queued at issue time; a monitor pops and checks them on each done pulse.
// Moves and no-op codes are checked directly right after the accepting edge.
module tb_mul_div_unit;

    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand1, operand2;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, div_by_zero;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .operand1    (operand1),
        .operand2    (operand2),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cycles;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic        exp_dbz = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic. SV signed division truncates toward zero and the
    // remainder follows the dividend, and MIN/-1 done in 64 bits wraps to LO=MIN, HI=0.
    function automatic exp_t ref_model(input logic [2:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, q, r;
        logic [63:0] u;
        logic [31:0] mb;
        int          hb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.dbz    = 1'b0;
        e.cycles = 32;
        e.hi     = '0;
        e.lo     = '0;
        if (o == MULTU) begin
            u = {32'd0, a} * {32'd0, b};
            e.hi = u[63:32]; e.lo = u[31:0];
        end else if (o == MULT) begin
            u = 64'(sa * sb);
            e.hi = u[63:32]; e.lo = u[31:0];
        end else if (b == 32'd0) begin
            e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
        end else if (o == DIVU) begin
            e.lo = a / b; e.hi = a % b;
        end else begin
            q = sa / sb; r = sa % sb;
            u = 64'(q); e.lo = u[31:0];
            u = 64'(r); e.hi = u[31:0];
        end
`ifdef MDU_EARLY_OUT_EN
        if (o == MULT || o == MULTU) begin
            mb = (o == MULT && b[31]) ? -b : b;
            hb = 0;
            for (int i = 0; i < 32; i++) if (mb[i]) hb = i + 1;
            e.cycles = (hb < 1) ? 1 : hb;
        end else if (b == 32'd0) begin
            e.cycles = 1;
        end
`else
        mb = '0;
        hb = 0;
        if (mb != 32'd0 || hb != 0) e.cycles = 0;
`endif
        return e;
    endfunction

    // Monitor: counts busy cycles and checks each done pulse against the queue head.
    initial begin
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL done_unexpected: got done=1, expected no pending op (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("hi_out", hi_out, e.hi);
                    check("lo_out", lo_out, e.lo);
                    check("div_by_zero", div_by_zero, e.dbz);
                    check("busy_cycles", busy_cnt, e.cycles);
                end
                busy_cnt = 0;
            end else if (busy === 1'b1) begin
                busy_cnt++;
            end else begin
                busy_cnt = 0;
            end
        end
    end

    // Called at posedge+#1; holds start across one edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        start = 1'b1; op = o; operand1 = a; operand2 = b;
        if (o <= DIVU) begin
            e = ref_model(o, a, b);
            sb_q.push_back(e);
            exp_hi = e.hi; exp_lo = e.lo; exp_dbz = e.dbz;
        end else if (o == MTHI) begin
            exp_hi = a;
        end else if (o == MTLO) begin
            exp_lo = a;
        end
        @(posedge clk); #1;
        start = 1'b0;
        op = 3'($urandom);
        operand1 = $urandom;
        operand2 = $urandom;
    endtask

    // Raw start pulse with no expectation, for requests the unit must ignore.
    task automatic pulse_ignored(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; operand1 = a; operand2 = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle_busy", busy, 1'b0);
    endtask

    task automatic check_idle_regs(input string tag);
        check({tag, "_hi"}, hi_out, exp_hi);
        check({tag, "_lo"}, lo_out, exp_lo);
        check({tag, "_dbz"}, div_by_zero, exp_dbz);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    logic [2:0]  d_op[12] = '{MULTU, MULT, DIVU, DIV, DIV, DIV, DIVU, MULTU,
                              MULTU, MULTU, DIVU, DIV};
    logic [31:0] d_a[12]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9,
                              32'd7, 32'h8000_0000, 32'd5, 32'd2,
                              32'd5, 32'd1, 32'd8, 32'hFFFF_FFF0};
    logic [31:0] d_b[12]  = '{32'hFFFF_FFFF, 32'd7, 32'd7, 32'd2,
                              32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd3,
                              32'd3, 32'd0, 32'd0, 32'd0};
    logic [31:0] special[4] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000};

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;
        rst = 1'b1; start = 1'b0; op = '0; operand1 = '0; operand2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_done", done, 1'b0);
        check_idle_regs("reset");

        for (int i = 0; i < 12; i++) begin
            wait_idle();
            issue(d_op[i], d_a[i], d_b[i]);
        end

        // Requests while busy are dropped, including moves; a start in the done cycle is taken.
        wait_idle();
        issue(MULTU, 32'd3, 32'd4);
        repeat (3) begin @(posedge clk); #1; end
        pulse_ignored(DIVU, 32'd9, 32'd3);
        pulse_ignored(MTHI, 32'hDEAD_BEEF, 32'd0);
        wait_idle();
        check("done_cycle_pulse", done, 1'b1);
        issue(DIVU, 32'd9, 32'd3);

        // Reset mid-operation aborts with no done and clears everything.
        wait_idle();
        issue(MULT, 32'h1234_5678, 32'h7FFF_FFFF);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb_q.pop_back());
        exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
        check("abort_done", done, 1'b0);
        check_idle_regs("abort");
        issue(MTHI, 32'h0000_1234, 32'd0);
        check_idle_regs("mthi");
        issue(MTLO, 32'h0000_ABCD, 32'd0);
        check_idle_regs("mtlo");
        issue(3'b110, 32'h5555_5555, 32'd1);
        check_idle_regs("noop110");

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            wait_idle();
            issue(o, a, b);
            if (o > DIVU) check_idle_regs("rand_move");
        end

        wait_idle();
        repeat (3) begin @(posedge clk); #1; end
        check("scoreboard_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
